// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
package alu_arb_pkg;

   localparam int NUM_REQ = 2;

   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_O = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] id2oh(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational MIPS ALU: R-type and immediate ops on regA/regB.
// Flags are {zero, negative, signed overflow}; unknown opcodes give 0.
module alu
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [31:0]      instruction,
   input  logic [WIDTH-1:0] rega,
   input  logic [WIDTH-1:0] regb,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flags
);

   logic [5:0]       op;
   logic [5:0]       funct;
   logic [4:0]       shamt;
   logic [WIDTH-1:0] imm_s;
   logic [WIDTH-1:0] imm_z;
   logic             ovf;
   logic             unused_fields;

   assign op    = instruction[31:26];
   assign funct = instruction[5:0];
   assign shamt = instruction[10:6];
   assign imm_s = {{(WIDTH-16){instruction[15]}}, instruction[15:0]};
   assign imm_z = {{(WIDTH-16){1'b0}}, instruction[15:0]};
   assign unused_fields = ^instruction[25:16];

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (op)
         6'h00: begin
            case (funct)
               6'h00: result = regb << shamt;
               6'h02: result = regb >> shamt;
               6'h03: result = $signed(regb) >>> shamt;
               6'h20: begin
                  result = rega + regb;
                  ovf = (rega[WIDTH-1] == regb[WIDTH-1]) &&
                        (result[WIDTH-1] != rega[WIDTH-1]);
               end
               6'h21: result = rega + regb;
               6'h22: begin
                  result = rega - regb;
                  ovf = (rega[WIDTH-1] != regb[WIDTH-1]) &&
                        (result[WIDTH-1] != rega[WIDTH-1]);
               end
               6'h23: result = rega - regb;
               6'h24: result = rega & regb;
               6'h25: result = rega | regb;
               6'h26: result = rega ^ regb;
               6'h27: result = ~(rega | regb);
               6'h2a: result = {{(WIDTH-1){1'b0}},
                                $signed(rega) < $signed(regb)};
               6'h2b: result = {{(WIDTH-1){1'b0}}, rega < regb};
               default: result = '0;
            endcase
         end
         6'h08: begin
            result = rega + imm_s;
            ovf = (rega[WIDTH-1] == imm_s[WIDTH-1]) &&
                  (result[WIDTH-1] != rega[WIDTH-1]);
         end
         6'h09: result = rega + imm_s;
         6'h0a: result = {{(WIDTH-1){1'b0}},
                          $signed(rega) < $signed(imm_s)};
         6'h0b: result = {{(WIDTH-1){1'b0}}, rega < imm_s};
         6'h0c: result = rega & imm_z;
         6'h0d: result = rega | imm_z;
         6'h0e: result = rega ^ imm_z;
         6'h0f: result = {instruction[15:0], {(WIDTH-16){1'b0}}};
         default: result = '0;
      endcase
   end

   always_comb begin
      flags         = '0;
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[WIDTH-1];
      flags[FLAG_O] = ovf;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one ALU; ops run IDLE -> EXEC -> RESP.
// Define ALU_ARB_RR_EN for round-robin, else requester 0 has fixed priority.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [31:0]      req_instr0,
   input  logic [31:0]      req_instr1,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_b1,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [2:0]       rsp_flags,
   output logic             rsp_id
);

   arb_state_e       state_q;
   arb_state_e       state_d;
   logic             prio;
   logic             gnt;
   logic             accept;
   logic             done;
   logic [31:0]      op_instr;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_id;
   logic [WIDTH-1:0] alu_result;
   logic [2:0]       alu_flags;

`ifdef ALU_ARB_RR_EN
   logic prio_q;

   // Hand priority to whoever was not just served.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q <= 1'b0;
      end else if (done) begin
         prio_q <= ~rsp_id;
      end
   end

   assign prio = prio_q;
`else
   assign prio = 1'b0;
`endif

   always_comb begin
      gnt = prio;
      unique case (1'b1)
         (req_valid == 2'b01): gnt = 1'b0;
         (req_valid == 2'b10): gnt = 1'b1;
         default:              gnt = prio;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      accept    = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = reset ? 2'b00 : id2oh(gnt);
            accept    = !reset && req_valid[gnt];
            if (accept) state_d = EXEC;
         end
         EXEC: state_d = RESP;
         RESP: begin
            done = rsp_ready[rsp_id];
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         op_instr   <= '0;
         op_a       <= '0;
         op_b       <= '0;
         op_id      <= 1'b0;
         rsp_valid  <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_id     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_instr <= gnt ? req_instr1 : req_instr0;
            op_a     <= gnt ? req_a1 : req_a0;
            op_b     <= gnt ? req_b1 : req_b0;
            op_id    <= gnt;
         end
         if (state_q == EXEC) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_id     <= op_id;
            rsp_valid  <= id2oh(op_id);
         end
         if (done) rsp_valid <= '0;
      end
   end

   alu #(
      .WIDTH(WIDTH)
   ) u_alu (
      .instruction(op_instr),
      .rega       (op_a),
      .regb       (op_b),
      .result     (alu_result),
      .flags      (alu_flags)
   );

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, scoreboard, corner cases.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        v0, v1;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] i0, i1, a0, a1, b0, b1;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_result;
   logic [2:0]  rsp_flags;
   logic        rsp_id;

   int checks   = 0;
   int failures = 0;
   bit ok, okc0, okc1;

   typedef struct {
      logic        id;
      logic [31:0] result;
      logic [2:0]  flags;
   } exp_t;

   typedef struct {
      logic        port;
      logic [31:0] instr;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] result;
      logic [2:0]  flags;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[12];

   assign req_valid = {v1, v0};

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_instr0(i0),
      .req_instr1(i1),
      .req_a0    (a0),
      .req_a1    (a1),
      .req_b0    (b0),
      .req_b1    (b1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_result(rsp_result),
      .rsp_flags (rsp_flags),
      .rsp_id    (rsp_id)
   );

   function automatic logic [1:0] oh(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Response scoreboard: compare on each consuming handshake.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset && (rsp_valid & rsp_ready) != 2'b00) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp actual=%h required=none",
                     rsp_result);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
            chk("rsp_result", rsp_result, e.result);
            chk("rsp_flags", {29'b0, rsp_flags}, {29'b0, e.flags});
            chk("rsp_valid", {30'b0, rsp_valid}, {30'b0, oh(e.id)});
         end
      end
   end

   task automatic drive(input logic p, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      if (p) begin
         i1 = ins; a1 = a; b1 = b; v1 = 1'b1;
      end else begin
         i0 = ins; a0 = a; b0 = b; v0 = 1'b1;
      end
   endtask

   task automatic wait_accept(input logic p, output bit got);
      got = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (req_ready[p] && req_valid[p]) begin
            @(posedge clk);
            #1;
            got = 1'b1;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=none required=port%0d", p);
   endtask

   task automatic wait_rsp();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rsp_valid != 2'b00) return;
      end
      checks++;
      failures++;
      $display("FAIL rsp_timeout actual=%b required=nonzero", rsp_valid);
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   task automatic run_vec(input vec_t v);
      exp_q.push_back('{v.port, v.result, v.flags});
      drive(v.port, v.instr, v.a, v.b);
      wait_accept(v.port, ok);
      if (v.port) v1 = 1'b0;
      else v0 = 1'b0;
      @(negedge clk);
      chk("lat_exec", {30'b0, rsp_valid}, 0);
      @(negedge clk);
      chk("lat_resp", {30'b0, rsp_valid}, {30'b0, oh(v.port)});
      @(negedge clk);
      chk("lat_idle", {30'b0, rsp_valid}, 0);
   endtask

   // Called #1 after the edge that released reset.
   task automatic post_reset_check(input string tag);
      chk({tag, "_valid"}, {30'b0, rsp_valid}, 0);
      chk({tag, "_result"}, rsp_result, 0);
      chk({tag, "_flags"}, {29'b0, rsp_flags}, 0);
      chk({tag, "_id"}, {31'b0, rsp_id}, 0);
      exp_q.push_back('{1'b0, 32'h31, 3'b000});
      i0 = 32'h20090001; a0 = 32'h30; b0 = 0;
      i1 = 32'h20090001; a1 = 32'h40; b1 = 0;
      v0 = 1'b1;
      v1 = 1'b1;
      wait_accept(1'b0, ok);
      v0 = 1'b0;
      v1 = 1'b0;
      wait_drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, 32'h2009000D, 32'h3, 32'h0, 32'h10, 3'b000};
      vecs[1]  = '{1'b1, 32'h00014020, 32'h40000000, 32'h40000000,
                   32'h80000000, 3'b011};
      vecs[2]  = '{1'b0, 32'h00014022, 32'h5, 32'h5, 32'h0, 3'b100};
      vecs[3]  = '{1'b1, 32'h00014022, 32'h0, 32'h1, 32'hFFFFFFFF, 3'b010};
      vecs[4]  = '{1'b0, 32'h00014024, 32'hF0F0F0F0, 32'hFF00FF00,
                   32'hF000F000, 3'b010};
      vecs[5]  = '{1'b1, 32'h00014025, 32'hF, 32'hF0, 32'hFF, 3'b000};
      vecs[6]  = '{1'b0, 32'h0001402A, 32'hFFFFFFFF, 32'h1, 32'h1, 3'b000};
      vecs[7]  = '{1'b1, 32'h3C091234, 32'h0, 32'h0, 32'h12340000, 3'b000};
      vecs[8]  = '{1'b0, 32'h00014100, 32'h0, 32'h1, 32'h10, 3'b000};
      vecs[9]  = '{1'b1, 32'h2009FFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 3'b010};
      vecs[10] = '{1'b0, 32'h00014022, 32'h80000000, 32'h1,
                   32'h7FFFFFFF, 3'b001};
      vecs[11] = '{1'b1, 32'h3409FFFF, 32'h0, 32'h0, 32'h0000FFFF, 3'b000};

      reset = 1'b1;
      v0 = 1'b0; v1 = 1'b0;
      i0 = 0; i1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0;
      rsp_ready = 2'b11;

      // Reset state, with both requests pending.
      @(posedge clk); #1;
      v0 = 1'b1; v1 = 1'b1;
      @(negedge clk);
      chk("reset_ready", {30'b0, req_ready}, 0);
      chk("reset_valid", {30'b0, rsp_valid}, 0);
      chk("reset_result", rsp_result, 0);
      chk("reset_flags", {29'b0, rsp_flags}, 0);
      chk("reset_id", {31'b0, rsp_id}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      v0 = 1'b0; v1 = 1'b0;

      foreach (vecs[k]) run_vec(vecs[k]);
      wait_drain();

      // Contention: both ports keep four ops each queued.
      for (int k = 0; k < 8; k++) begin
         logic p;
         int   n;
`ifdef ALU_ARB_RR_EN
         p = k[0];
         n = k / 2;
`else
         p = (k >= 4);
         n = k % 4;
`endif
         exp_q.push_back('{p, (p ? 32'h100 : 32'h0) + n + 1, 3'b000});
      end
      @(posedge clk); #1;
      fork
         begin
            for (int n = 0; n < 4; n++) begin
               i0 = 32'h20090001; a0 = n; b0 = 0; v0 = 1'b1;
               wait_accept(1'b0, okc0);
            end
            v0 = 1'b0;
         end
         begin
            for (int n = 0; n < 4; n++) begin
               i1 = 32'h20090001; a1 = 32'h100 + n; b1 = 0; v1 = 1'b1;
               wait_accept(1'b1, okc1);
            end
            v1 = 1'b0;
         end
      join
      wait_drain();

      // Backpressure: hold the response for five cycles.
      rsp_ready = 2'b00;
      exp_q.push_back('{1'b0, 32'h14, 3'b000});
      drive(1'b0, 32'h2009000D, 32'h7, 32'h0);
      wait_accept(1'b0, ok);
      v0 = 1'b0;
      wait_rsp();
      i1 = 32'h2009000D; a1 = 32'h1; b1 = 0; v1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", {30'b0, rsp_valid}, 1);
         chk("bp_result", rsp_result, 32'h14);
         chk("bp_flags", {29'b0, rsp_flags}, 0);
         chk("bp_id", {31'b0, rsp_id}, 0);
         chk("bp_req_ready", {30'b0, req_ready}, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 2'b01;
      v1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_done", {30'b0, rsp_valid}, 0);

      // Non-owner ready must not consume the response.
      rsp_ready = 2'b10;
      exp_q.push_back('{1'b0, 32'h2D, 3'b000});
      drive(1'b0, 32'h2009000D, 32'h20, 32'h0);
      wait_accept(1'b0, ok);
      v0 = 1'b0;
      wait_rsp();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("nonowner_valid", {30'b0, rsp_valid}, 1);
         chk("nonowner_req_ready", {30'b0, req_ready}, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 2'b01;
      @(negedge clk);
      @(negedge clk);
      chk("nonowner_done", {30'b0, rsp_valid}, 0);
      rsp_ready = 2'b11;

      // Reset while the op is in EXEC.
      drive(1'b0, 32'h2009000D, 32'h55, 32'h0);
      wait_accept(1'b0, ok);
      reset = 1'b1;
      v0 = 1'b0;
      @(negedge clk);
      chk("rst_exec_ready", {30'b0, req_ready}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      post_reset_check("rst_exec");

      // Reset while port 1 holds a response in RESP.
      rsp_ready = 2'b00;
      drive(1'b1, 32'h2009000D, 32'h5, 32'h0);
      wait_accept(1'b1, ok);
      v1 = 1'b0;
      wait_rsp();
      chk("rst_resp_pre", {30'b0, rsp_valid}, 2);
      @(posedge clk); #1;
      reset = 1'b1;
      v0 = 1'b1;
      v1 = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_resp_ready", {30'b0, req_ready}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      rsp_ready = 2'b11;
      post_reset_check("rst_resp");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
